// File: rtl/cover_art_loader_if.sv
// Byte-stream in / pixel-write out bundle for cover_art_loader.
// The loader connects through the slave modport; the stream source and memory side use master.
interface cover_art_loader_if #(
    parameter int ADDR_W = 17
);
    logic              Start;
    logic [7:0]        InByte;
    logic              InValid;
    logic              InReady;
    logic [ADDR_W-1:0] WrAddr;
    logic [3:0]        WrData;
    logic              WrEn;
    logic              WrBank;
    logic              Busy;
    logic              Done;
    logic              Error;

    modport master (
        output Start, InByte, InValid,
        input  InReady, WrAddr, WrData, WrEn, WrBank, Busy, Done, Error
    );

    modport slave (
        input  Start, InByte, InValid,
        output InReady, WrAddr, WrData, WrEn, WrBank, Busy, Done, Error
    );
endinterface

// File: rtl/cover_art_loader.sv
// Unpacks a header-tagged byte stream into 4-bit pixels, two pixel writes per byte.
// Optional trailing checksum byte when CHECKSUM_EN is defined.
module cover_art_loader #(
    parameter int NUM_PIXELS = 90000,
    parameter int ADDR_W     = 17
) (
    input logic               CLOCK,
    input logic               RESET_N,
    cover_art_loader_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] HI   = 3'd2;
    localparam logic [2:0] LO   = 3'd3;
`ifdef CHECKSUM_EN
    localparam logic [2:0] CHK  = 3'd4;
`endif
    localparam logic [2:0] FIN  = 3'd5;

    // Pointer value while writing the final pixel pair.
    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_PIXELS - 2);

    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [3:0]        wr_data_reg;
    logic [3:0]        lo_nib_reg;
    logic              wr_en_reg;
    logic              wr_bank_reg;
    logic              error_reg;
    logic              in_ready;
    logic              accept;
    logic              hdr_ok;
    logic              last_pair;
`ifdef CHECKSUM_EN
    logic [7:0]        csum_reg;
`endif

    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            HDR, HI: in_ready = 1'b1;
`ifdef CHECKSUM_EN
            CHK:     in_ready = 1'b1;
`endif
            default: in_ready = 1'b0;
        endcase
        accept    = in_ready & bus.InValid;
        hdr_ok    = (bus.InByte[7:1] == 7'b1010000);
        last_pair = (ptr_reg == LAST_PAIR);

        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.Start) state_next = HDR;
            HDR:  if (accept) state_next = hdr_ok ? HI : IDLE;
            HI:   if (accept) state_next = LO;
`ifdef CHECKSUM_EN
            LO:   state_next = last_pair ? CHK : HI;
            CHK:  if (accept) state_next = (bus.InByte == csum_reg) ? FIN : IDLE;
`else
            LO:   state_next = last_pair ? FIN : HI;
`endif
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            lo_nib_reg  <= '0;
            wr_en_reg   <= 1'b0;
            wr_bank_reg <= 1'b0;
            error_reg   <= 1'b0;
`ifdef CHECKSUM_EN
            csum_reg    <= '0;
`endif
        end else begin
            state_reg <= state_next;
            wr_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.Start) begin
                        error_reg <= 1'b0;
                        ptr_reg   <= '0;
`ifdef CHECKSUM_EN
                        csum_reg  <= '0;
`endif
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (hdr_ok) wr_bank_reg <= bus.InByte[0];
                        else        error_reg   <= 1'b1;
                    end
                end
                HI: begin
                    if (accept) begin
                        wr_en_reg   <= 1'b1;
                        wr_data_reg <= bus.InByte[7:4];
                        wr_addr_reg <= ptr_reg;
                        lo_nib_reg  <= bus.InByte[3:0];
`ifdef CHECKSUM_EN
                        csum_reg    <= csum_reg + bus.InByte;
`endif
                    end
                end
                LO: begin
                    wr_en_reg   <= 1'b1;
                    wr_data_reg <= lo_nib_reg;
                    wr_addr_reg <= ptr_reg + ADDR_W'(1);
                    // Wrap to zero after the last pair so the pointer never leaves the bank.
                    ptr_reg     <= last_pair ? '0 : ptr_reg + ADDR_W'(2);
                end
`ifdef CHECKSUM_EN
                CHK: begin
                    if (accept && (bus.InByte != csum_reg)) error_reg <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.InReady = in_ready;
    assign bus.WrAddr  = wr_addr_reg;
    assign bus.WrData  = wr_data_reg;
    assign bus.WrEn    = wr_en_reg;
    assign bus.WrBank  = wr_bank_reg;
    assign bus.Busy    = (state_reg != IDLE);
    assign bus.Done    = (state_reg == FIN);
    assign bus.Error   = error_reg;
endmodule

// File: doc/cover_art_loader.md
COVER_ART_LOADER -- requirements
Module: cover_art_loader

Interface
REQ-001 NUM_PIXELS, 90000, pixels per cover-art bank; SHALL be even and ≥2.
REQ-002 ADDR_W, 17, width of WrAddr; SHALL satisfy 2^ADDR_W ≥ NUM_PIXELS.
REQ-003 CLOCK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RESET_N  in  1  reset, synchronous, active-low.
REQ-005 Start  in  1  one-cycle request to begin a load.
REQ-006 InByte  in  8  stream byte.
REQ-007 InValid  in  1  InByte valid.
REQ-008 InReady  out  1  loader accepts InByte; transfer occurs when InValid&InReady at an edge.
REQ-009 WrAddr  out  ADDR_W  pixel address into the selected 4-bit cover-art memory.
REQ-010 WrData  out  4  palette index to write.
REQ-011 WrEn  out  1  write strobe, one pixel per cycle.
REQ-012 WrBank  out  1  0 = first-song bank, 1 = second-song bank.
REQ-013 Busy  out  1  high in any state other than IDLE.
REQ-014 Done  out  1  one-cycle pulse on successful completion.
REQ-015 Error  out  1  sticky failure flag, cleared on next accepted Start.

Function
REQ-016 States SHALL be IDLE, HDR, HI, LO, CHK (CHECKSUM_EN only), FIN.
REQ-017 IDLE: InReady=0; Start → HDR, clears Error, pixel pointer=0, checksum=0; Start in any other state ignored.
REQ-018 HDR: InReady=1; accepted byte 0xA0/0xA1 → WrBank<=byte[0], go HI; any other byte → Error=1, go IDLE, no Done, no writes.
REQ-019 HI: InReady=1 combinationally; on accept, next edge drives WrEn=1, WrData=InByte[7:4], WrAddr=ptr, latches InByte[3:0], go LO.
REQ-020 LO: InReady=0; next edge drives WrEn=1, WrData=latched low nibble, WrAddr=ptr+1; ptr+=2.
REQ-021 Byte accepted at edge t SHALL produce writes visible in cycles t+1 (high nibble) and t+2 (low nibble); WrEn=0 in all other cycles.
REQ-022 Peak throughput one byte per 2 cycles; InValid low in HI SHALL stall with WrEn=0 and no pointer change.
REQ-023 After the LO write of pixel NUM_PIXELS-1: go CHK if CHECKSUM_EN, else FIN; pointer SHALL never exceed NUM_PIXELS-1 on WrAddr.
REQ-024 FIN: Done=1 for exactly one cycle, then IDLE; WrBank holds its value until next header.
REQ-025 Checksum: 8-bit modulo-256 sum of all data bytes (header excluded), wraps silently.

Reset
REQ-026 RESET_N=0 at an edge SHALL force IDLE and on that edge set WrEn=0, WrAddr=0, WrData=0, WrBank=0, Busy=0, Done=0, Error=0, pointer=0, checksum=0; InReady=0.
REQ-027 Reset mid-load SHALL abort with no further writes and no Done; next Start restarts from address 0.

Configuration
REQ-028 CHECKSUM_EN defined: CHK state has InReady=1; accepted byte equal to checksum → FIN; unequal → Error=1, IDLE, no Done.
REQ-029 CHECKSUM_EN undefined: no CHK state, no checksum register; Error only from bad header; stream ends after last data byte.

Verification
REQ-030 NUM_PIXELS=4, Start, bytes A1,12,34 (CHECKSUM_EN off) -> writes (0,1),(1,2),(2,3),(3,4) with WrBank=1, then Done one cycle, Busy low.
REQ-031 Same with CHECKSUM_EN, trailing 46 -> Done=1, Error=0; trailing 47 -> Error=1, no Done.
REQ-032 Header 0x55 -> Error=1, zero WrEn cycles, back to IDLE; next Start clears Error.
REQ-033 InValid toggled 1/0 every cycle during data -> InReady low in LO, no lost/duplicated pixels, addresses strictly 0..NUM_PIXELS-1.
REQ-034 RESET_N low for one cycle after 2 data bytes -> WrEn=0 next cycle, Busy=0; fresh load writes from address 0.
REQ-035 Start pulsed during HI -> ignored; transfer completes unchanged.
